// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, state and latency definitions for the ALU controller
package alu_pkg;
    localparam int DATA_WIDTH = 16;
    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;
    localparam int LAT_SIMPLE = 0;
    localparam int LAT_MUL    = 1;
    localparam int LAT_DIV    = 3;
    localparam int LAT_MAX    = LAT_DIV;
    localparam int CNT_W      = $clog2(LAT_MAX + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;
    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] oc);
        return oc == OC_MUL ? CNT_W'(LAT_MUL) : oc == OC_DIV ? CNT_W'(LAT_DIV) : CNT_W'(LAT_SIMPLE);
    endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational datapath, result truncated to DATA_WIDTH bits
//   oc_i  opcode
//   a_i   operand A
//   b_i   operand B (ignored by NOT)
//   f_o   result; divide by zero yields 0 here and is overridden by the caller
module alu
    import alu_pkg::*;
(
    input  logic [2:0]            oc_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] f_o
);
    always_comb begin
        f_o = '0;
        case (oc_i)
            OC_ADD:  f_o = a_i + b_i;
            OC_SUB:  f_o = a_i - b_i;
            OC_MUL:  f_o = a_i * b_i;
            OC_DIV:  f_o = b_i == '0 ? '0 : a_i / b_i;
            OC_NOT:  f_o = ~a_i;
            OC_XOR:  f_o = a_i ^ b_i;
            OC_OR:   f_o = a_i | b_i;
            OC_AND:  f_o = a_i & b_i;
            default: f_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: single-command ALU controller with per-opcode latency and valid/ready handshakes
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; ready only in IDLE
//   cmd_oc, cmd_a, cmd_b  opcode and operands, captured on accept
//   res_valid/res_ready   result handshake; result held until taken
//   res_f, res_err        result and divide-by-zero flag
module alu_ctrl
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_oc,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_f,
    output logic                  res_err
);
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            oc_q, oc_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_f_q, res_f_d;
    logic                  res_err_q, res_err_d;
    logic [DATA_WIDTH-1:0] alu_f;
    logic                  div_zero;

    alu u_alu (
        .oc_i (oc_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .f_o  (alu_f)
    );

    assign div_zero  = oc_q == OC_DIV && b_q == '0;
    assign cmd_ready = state_q == IDLE;
    assign res_valid = res_valid_q;
    assign res_f     = res_f_q;
    assign res_err   = res_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        oc_d        = oc_q;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = res_valid_q;
        res_f_d     = res_f_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                oc_d    = cmd_oc;
                a_d     = cmd_a;
                b_d     = cmd_b;
                cnt_d   = lat_of(cmd_oc);
                state_d = EXEC;
            end
            EXEC: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                res_f_d     = div_zero ? '1 : alu_f;
                res_err_d   = div_zero;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: if (res_ready) begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            oc_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_f_q     <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            oc_q        <= oc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_f_q     <= res_f_d;
            res_err_q   <= res_err_d;
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed self-checking bench for alu_ctrl
module tb_alu_ctrl;
    logic        clk, rst_n, cmd_valid, cmd_ready, res_valid, res_ready, res_err;
    logic [2:0]  cmd_oc;
    logic [15:0] cmd_a, cmd_b, res_f;
    int n_cmp = 0;
    int n_bad = 0;

    alu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_oc    (cmd_oc),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_f     (res_f),
        .res_err   (res_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one command from IDLE, scrambles cmd_* while it executes, and
    // measures cycles from the accepting edge to the first res_valid cycle.
    task automatic issue(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b,
                         input logic ack, output int lat, output logic [15:0] f, output logic e);
        @(negedge clk);
        cmd_oc = oc; cmd_a = a; cmd_b = b; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            cmd_oc = 3'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        f = res_f; e = res_err;
        if (ack) begin
            res_ready = 1;
            @(posedge clk); #1;
            res_ready = 0;
        end
    endtask

    task automatic test_reset;
        rst_n = 0; cmd_valid = 1; cmd_oc = 3'b010; cmd_a = 16'h1234; cmd_b = 16'h5678; res_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_cmp++; if (res_f !== 16'h0000) begin n_bad++; $display("FAIL reset_res_f got %h want 0000", res_f); end
        n_cmp++; if (res_err !== 1'b0) begin n_bad++; $display("FAIL reset_res_err got %b want 0", res_err); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        rst_n = 1; cmd_valid = 0; res_ready = 0;
    endtask

    task automatic test_ready_idle;
        res_ready = 1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                n_bad++; $display("FAIL ready_idle got valid=%b ready=%b want valid=0 ready=1", res_valid, cmd_ready);
            end
        end
        res_ready = 0;
    endtask

    task automatic test_add;
        int lat; logic [15:0] f; logic e;
        issue(3'b000, 16'hFFFF, 16'h0002, 1, lat, f, e);
        n_cmp++; if (f !== 16'h0001) begin n_bad++; $display("FAIL add_f got %h want 0001", f); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL add_err got %b want 0", e); end
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL add_lat got %0d want 2", lat); end
    endtask

    task automatic test_mul;
        int lat; logic [15:0] f; logic e;
        issue(3'b010, 16'h0100, 16'h0101, 1, lat, f, e);
        n_cmp++; if (f !== 16'h0100) begin n_bad++; $display("FAIL mul_f got %h want 0100", f); end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL mul_lat got %0d want 3", lat); end
    endtask

    task automatic test_div_zero;
        int lat; logic [15:0] f; logic e;
        issue(3'b011, 16'd5, 16'd0, 1, lat, f, e);
        n_cmp++; if (f !== 16'hFFFF) begin n_bad++; $display("FAIL div0_f got %h want ffff", f); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL div0_err got %b want 1", e); end
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL div0_lat got %0d want 5", lat); end
    endtask

    task automatic test_div;
        int lat; logic [15:0] f; logic e;
        issue(3'b011, 16'd100, 16'd7, 1, lat, f, e);
        n_cmp++; if (f !== 16'd14) begin n_bad++; $display("FAIL div_f got %h want 000e", f); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL div_err got %b want 0", e); end
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL div_lat got %0d want 5", lat); end
    endtask

    task automatic test_logic;
        logic [2:0]  ocs [4] = '{3'b100, 3'b101, 3'b110, 3'b111};
        logic [15:0] as  [4] = '{16'h00FF, 16'hA5A5, 16'hA000, 16'hF0F0};
        logic [15:0] bs  [4] = '{16'h1234, 16'h0FF0, 16'h0005, 16'h3C3C};
        logic [15:0] exp [4] = '{16'hFF00, 16'hAA55, 16'hA005, 16'h3030};
        int lat; logic [15:0] f; logic e;
        for (int i = 0; i < 4; i++) begin
            issue(ocs[i], as[i], bs[i], 1, lat, f, e);
            n_cmp++; if (f !== exp[i] || lat != 2) begin
                n_bad++; $display("FAIL logic_op%0d got f=%h lat=%0d want f=%h lat=2", i, f, lat, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [15:0] f; logic e;
        issue(3'b001, 16'd3, 16'd5, 0, lat, f, e);
        n_cmp++; if (f !== 16'hFFFE || lat != 2) begin
            n_bad++; $display("FAIL sub_result got f=%h lat=%0d want f=fffe lat=2", f, lat);
        end
        @(negedge clk);
        cmd_oc = 3'b000; cmd_a = 16'd1; cmd_b = 16'd1; cmd_valid = 1;
        repeat (10) begin
            @(negedge clk);
            n_cmp++; if (res_valid !== 1'b1 || res_f !== 16'hFFFE || cmd_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold got valid=%b f=%h ready=%b want valid=1 f=fffe ready=0", res_valid, res_f, cmd_ready);
            end
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        n_cmp++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL handshake_idle got valid=%b ready=%b want valid=0 ready=1", res_valid, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 0;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL second_accept got ready=%b want 0", cmd_ready); end
        @(posedge clk); #1;
        n_cmp++; if (res_valid !== 1'b1 || res_f !== 16'h0002) begin
            n_bad++; $display("FAIL second_result got valid=%b f=%h want valid=1 f=0002", res_valid, res_f);
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    task automatic test_reset_abort;
        int highs = 0;
        @(negedge clk);
        cmd_oc = 3'b011; cmd_a = 16'd200; cmd_b = 16'd3; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        n_cmp++; if (res_valid !== 1'b0 || res_f !== 16'h0000 || res_err !== 1'b0) begin
            n_bad++; $display("FAIL abort_outputs got valid=%b f=%h err=%b want all 0", res_valid, res_f, res_err);
        end
        rst_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b want 1", cmd_ready); end
        repeat (8) begin
            @(negedge clk);
            if (res_valid === 1'b1) highs++;
        end
        n_cmp++; if (highs != 0) begin n_bad++; $display("FAIL abort_no_result got %0d valid cycles want 0", highs); end
    endtask

    initial begin
        test_reset();
        test_ready_idle();
        test_add();
        test_mul();
        test_div_zero();
        test_div();
        test_logic();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
